// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction and data
// requesters of a core; one transaction in flight, watchdog forces an error reply.
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  i_response,
  output logic                  i_error,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  d_response,
  output logic                  d_error,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_response,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;
  localparam int   CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] cnt;

  logic i_act, d_act, pick_d, timeout, done;

  assign i_act = i_read | i_write;
  assign d_act = d_read | d_write;
  // Data wins when it is alone, or on a tie when instruction was served last.
  assign pick_d  = d_act & (~i_act | (last_grant == SEL_I));
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);
  assign done    = mem_response | timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= SEL_I;
      last_grant     <= SEL_D;
      cnt            <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      i_read_data    <= '0;
      i_response     <= 1'b0;
      i_error        <= 1'b0;
      d_read_data    <= '0;
      d_response     <= 1'b0;
      d_error        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_act | d_act) begin
            owner          <= pick_d;
            last_grant     <= pick_d;
            cnt            <= '0;
            mem_address    <= pick_d ? d_address : i_address;
            mem_write_data <= pick_d ? d_write_data : i_write_data;
            // A simultaneous read and write is treated as a write.
            mem_write      <= pick_d ? d_write : i_write;
            mem_read       <= pick_d ? (d_read & ~d_write) : (i_read & ~i_write);
            busy           <= 1'b1;
            state          <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RESP;
            // A real response beats a coincident timeout.
            if (owner == SEL_D) begin
              d_response  <= 1'b1;
              d_read_data <= mem_response ? mem_read_data : '0;
              d_error     <= ~mem_response;
            end else begin
              i_response  <= 1'b1;
              i_read_data <= mem_response ? mem_read_data : '0;
              i_error     <= ~mem_response;
            end
          end
        end
        RESP: begin
          i_response  <= 1'b0;
          i_error     <= 1'b0;
          i_read_data <= '0;
          d_response  <= 1'b0;
          d_error     <= 1'b0;
          d_read_data <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
Shares the Controller's single core memory port between two requesters of a core: the instruction port (i_*) and the data port (d_*). It uses round-robin arbitration with a registered grant. One transaction is outstanding at a time. A watchdog returns an error response to the requester if memory never answers. The block sits between the Core and the Controller's core_*_memory bus.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT_CYCLES, 1024, cycles in BUSY before forced error response; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_read  in  1  instruction read request, held until i_response
i_write  in  1  instruction write request, held until i_response
i_address  in  ADDR_WIDTH  instruction request address
i_write_data  in  DATA_WIDTH  instruction write data
i_read_data  out  DATA_WIDTH  read data, valid while i_response=1
i_response  out  1  one-cycle completion pulse
i_error  out  1  timeout flag, valid only while i_response=1
d_read, d_write, d_address, d_write_data, d_read_data, d_response, d_error: same as i_* for the data requester
mem_read  out  1  read strobe to Controller, held until mem_response
mem_write  out  1  write strobe to Controller, held until mem_response
mem_address  out  ADDR_WIDTH  registered address
mem_write_data  out  DATA_WIDTH  registered write data
mem_read_data  in  DATA_WIDTH  read data, valid with mem_response
mem_response  in  1  completion pulse from Controller
busy  out  1  high in BUSY and RESP states

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0.
  - last_grant=DATA, so the instruction port wins the first tie.
  - Watchdog counter=0.
- A requester is active when its read or write is high. If both read and write are high, the request is a write and mem_read stays 0.
- FSM IDLE:
  - Only one requester active: grant it.
  - Both active: grant the one that is not last_grant.
  - At the grant edge, register from the winner: address, write_data, mem_write, and mem_read (only if not writing). Also set owner and last_grant, clear the counter, and go to BUSY.
  - No request: stay in IDLE.
- FSM BUSY:
  - Hold all mem_* outputs stable.
  - Counter increments each cycle.
  - mem_response=1: at the edge, capture mem_read_data into the owner's read_data register, clear the owner's error, clear mem_read/mem_write, and go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no response (TIMEOUT_CYCLES≠0): same transition, but read_data=0 and the owner's error=1.
  - mem_response and timeout in the same cycle: the response wins and error=0.
- FSM RESP (exactly 1 cycle):
  - Owner's response=1 with its read_data and error.
  - The non-owner's response stays 0.
  - Next state is IDLE.
  - response, error and read_data return to 0 on leaving RESP.
- Requester contract: drop the request on the edge that ends the RESP cycle. The IDLE cycle after RESP therefore sees only fresh requests.
- Latency:
  - Request visible in IDLE cycle 0 → mem strobe in cycle 1.
  - mem_response in cycle k → requester response in cycle k+1 → IDLE in cycle k+2.
  - Minimum round trip is 3 cycles.
  - Back-to-back grant spacing is 1 idle cycle.
- A non-owner request arriving during BUSY/RESP waits. Its inputs are not sampled until the IDLE grant.
- mem_response while in IDLE or RESP is ignored (no state change, no pulse).
- Owner request inputs changing during BUSY do not affect mem_* outputs, because they are registered at grant.
- Reset mid-transaction: next cycle is IDLE, all strobes and responses 0, pending transaction discarded with no response pulse, last_grant=DATA.

Test Plan:
- Single instruction read of addr 0x100; memory responds 2 cycles after mem_read rises with 0xDEADBEEF → mem_address=0x100; i_response is a 1-cycle pulse with i_read_data=0xDEADBEEF and i_error=0; d_response stays 0.
- Instruction read and data write (addr 0x200, data 0x12345678) requested simultaneously from reset → instruction granted first. Data write issues 1 idle cycle after i_response with mem_write=1, mem_write_data=0x12345678.
- Both ports requesting continuously for 6 transactions → grants alternate I,D,I,D,I,D. Each port has exactly 3 response pulses.
- TIMEOUT_CYCLES=8, d_read with no mem_response → mem_read high for 8 cycles then dropped; d_response=1 with d_error=1 and d_read_data=0.
- mem_response asserted in the same cycle the counter hits the limit (TIMEOUT_CYCLES=8, response on 8th BUSY cycle) → d_error=0 and data is returned.
- reset asserted in BUSY with mem_read=1 → next cycle mem_read=0, busy=0, no response pulse. A subsequent simultaneous request grants the instruction port first.
